imem_loader: RTL and testbench

Byte-serial program loader that writes instruction words into the CPU's instruction/data memory before execution. It sits between a byte source (UART receiver or testbench stream) and the memory's write port, holding the single-cycle CPU in reset until a complete, checksum-valid image has been written. After a successful load it releases the CPU, which then fetches from `BASE_ADDR` onward.

---
 rtl/imem_loader.sv | 222 ++++++++++++++++++++++
 tb/tb_imem_loader.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Byte-serial program loader. It takes a little-endian length-prefixed image
// from a byte source, assembles 32-bit words, writes them into instruction
// memory starting at BASE_ADDR, and then checks a trailing 8-bit checksum.
// The CPU is held in reset until a complete, checksum-valid image has been
// written.
//
// Stream format: LEN_LO, LEN_HI, N x 4 data bytes (each word little-endian),
// CSUM. CSUM is the 8-bit wrapping sum of every byte before it, including
// both length bytes.
//
// Parameters:
//   BASE_ADDR      byte address of the first written word
//   MAX_WORDS      largest accepted image length in words
//
// Ports:
//   clk            clock, all state changes on the rising edge
//   rst            asynchronous active-high reset
//   in_valid       source has a byte on in_data
//   in_data        stream byte
//   in_ready       loader accepts a byte this cycle (decode of state)
//   mem_enable     memory enable, high only during a write
//   mem_wr         memory write strobe
//   mem_addr       byte address of the word being written
//   mem_data       word being written
//   cpu_rst        CPU reset hold, high until the load completes
//   done           image loaded and verified (sticky until rst)
//   error          length or checksum failure (sticky until rst)
//   words_written  count of memory writes issued
// ---------------------------------------------------------------------------
module imem_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0,
   parameter int unsigned MAX_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        mem_enable,
   output logic        mem_wr,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_data,
   output logic        cpu_rst,
   output logic        done,
   output logic        error,
   output logic [15:0] words_written
);

   localparam logic [31:0] MaxWordsW = 32'(MAX_WORDS);

   typedef enum logic [2:0] {
      LEN0,
      LEN1,
      DATA,
      WRITE,
      CSUM,
      DONE,
      ERR
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] len_q, len_d;
   logic [7:0]  sum_q, sum_d;
   logic [1:0]  byteIdx_q, byteIdx_d;
   logic [23:0] asm_q, asm_d;
   logic        memWr_q, memWr_d;
   logic [31:0] memAddr_q, memAddr_d;
   logic [31:0] memData_q, memData_d;
   logic [15:0] count_q, count_d;

   logic        accept;
   logic [15:0] lenFull;
   logic        lenTooBig;
   logic [31:0] wordAddr;

   // A byte moves only when the source offers one and the current state
   // is one that consumes stream bytes.
   always_comb begin
      in_ready = (state_q == LEN0) || (state_q == LEN1) ||
                 (state_q == DATA) || (state_q == CSUM);
   end

   // Helper terms: the full length as it will look once LEN_HI lands, the
   // oversize test on that length, and the address of the next word. The
   // write counter doubles as the word index because each word is written
   // exactly once, in order.
   always_comb begin
      accept    = in_valid && in_ready;
      lenFull   = {in_data, len_q[7:0]};
      lenTooBig = ({16'h0, lenFull} > MaxWordsW);
      wordAddr  = BASE_ADDR + {14'h0, count_q, 2'b00};
   end

   // State and datapath registers. Reset puts the loader back at the start
   // of a stream; memory contents already written are not touched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= LEN0;
         len_q     <= 16'h0;
         sum_q     <= 8'h0;
         byteIdx_q <= 2'd0;
         asm_q     <= 24'h0;
         memWr_q   <= 1'b0;
         memAddr_q <= BASE_ADDR;
         memData_q <= 32'h0;
         count_q   <= 16'h0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         sum_q     <= sum_d;
         byteIdx_q <= byteIdx_d;
         asm_q     <= asm_d;
         memWr_q   <= memWr_d;
         memAddr_q <= memAddr_d;
         memData_q <= memData_d;
         count_q   <= count_d;
      end
   end

   // Next-state and datapath update. The write strobe is a one-cycle
   // registered pulse set on the edge that takes a word's fourth byte, so
   // it lines up exactly with the WRITE state; address and data are loaded
   // on that same edge and then held.
   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      sum_d     = sum_q;
      byteIdx_d = byteIdx_q;
      asm_d     = asm_q;
      memWr_d   = 1'b0;
      memAddr_d = memAddr_q;
      memData_d = memData_q;
      count_d   = count_q;

      case (state_q)
         LEN0: begin
            if (accept) begin
               len_d   = {len_q[15:8], in_data};
               sum_d   = sum_q + in_data;
               state_d = LEN1;
            end
         end

         LEN1: begin
            if (accept) begin
               len_d     = lenFull;
               sum_d     = sum_q + in_data;
               byteIdx_d = 2'd0;
               if (lenTooBig) begin
                  state_d = ERR;
               end else if (lenFull == 16'h0) begin
                  state_d = CSUM;
               end else begin
                  state_d = DATA;
               end
            end
         end

         DATA: begin
            if (accept) begin
               sum_d     = sum_q + in_data;
               byteIdx_d = byteIdx_q + 2'd1;
               asm_d     = {in_data, asm_q[23:8]};
               if (byteIdx_q == 2'd3) begin
                  memWr_d   = 1'b1;
                  memData_d = {in_data, asm_q};
                  memAddr_d = wordAddr;
                  count_d   = count_q + 16'd1;
                  state_d   = WRITE;
               end
            end
         end

         WRITE: begin
            if (count_q == len_q) begin
               state_d = CSUM;
            end else begin
               state_d = DATA;
            end
         end

         CSUM: begin
            if (accept) begin
               if (in_data == sum_q) begin
                  state_d = DONE;
               end else begin
                  state_d = ERR;
               end
            end
         end

         DONE: begin
            state_d = DONE;
         end

         ERR: begin
            state_d = ERR;
         end

         default: begin
            state_d = ERR;
         end
      endcase
   end

   // Outputs are straight decodes of registered state, so done, error and
   // cpu_rst change only on clock edges or asynchronously with rst.
   always_comb begin
      mem_enable    = memWr_q;
      mem_wr        = memWr_q;
      mem_addr      = memAddr_q;
      mem_data      = memData_q;
      words_written = count_q;
      done          = (state_q == DONE);
      error         = (state_q == ERR);
      cpu_rst       = (state_q != DONE);
   end

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//
// Self-checking bench for imem_loader. A table of hand-worked images and a
// set of random images are streamed in; expected writes, final flags and
// write counts come from a simple byte-sum model of the stream. Extra
// hand-written sequences cover asynchronous reset and reset in mid-load.
// ---------------------------------------------------------------------------
module tb_imem_loader;

   localparam logic [31:0] BASE = 32'h0;
   localparam int          MAXW = 4;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        mem_enable;
   logic        mem_wr;
   logic [31:0] mem_addr;
   logic [31:0] mem_data;
   logic        cpu_rst;
   logic        done;
   logic        error;
   logic [15:0] words_written;

   int checks = 0;
   int fails  = 0;

   imem_loader #(
      .BASE_ADDR(BASE),
      .MAX_WORDS(MAXW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .mem_enable   (mem_enable),
      .mem_wr       (mem_wr),
      .mem_addr     (mem_addr),
      .mem_data     (mem_data),
      .cpu_rst      (cpu_rst),
      .done         (done),
      .error        (error),
      .words_written(words_written)
   );

   // Free-running clock, 10 ns period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Every cycle with either memory control high is logged, so a stretched
   // or missing strobe shows up as a wrong number of log entries.
   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic        en;
      logic        wr;
      logic        rdy;
   } wrRec_t;

   wrRec_t writes[$];

   always @(negedge clk) begin
      if (mem_wr || mem_enable) begin
         writes.push_back('{mem_addr, mem_data, mem_enable, mem_wr, in_ready});
      end
   end

   typedef struct {
      logic [15:0] len;
      logic [31:0] w [4];
      logic [7:0]  csum;
      bit          expDone;
      bit          expErr;
      int          expWrites;
      string       tag;
   } vec_t;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Reference checksum: wrapping byte sum of both length bytes and every
   // data byte of the first len words.
   function automatic logic [7:0] refChecksum(input logic [15:0] len,
                                              input logic [31:0] w [4]);
      int s;
      s = int'(len) % 256 + int'(len) / 256;
      for (int i = 0; i < int'(len) && i < 4; i++) begin
         for (int k = 0; k < 4; k++) begin
            s += int'((w[i] >> (8 * k)) & 32'hFF);
         end
      end
      return 8'(s % 256);
   endfunction

   // Offer one byte, optionally after a random idle gap; returns at the
   // falling edge after the edge that took it. in_valid is left high so a
   // following call with no gap presents back-to-back bytes.
   task automatic sendByte(input logic [7:0] b, input int gapMax, output bit accepted);
      int gap;
      gap = (gapMax > 0) ? int'($urandom_range(gapMax, 0)) : 0;
      repeat (gap) begin
         in_valid = 1'b0;
         in_data  = 8'($urandom);
         @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = b;
      accepted = 1'b0;
      for (int t = 0; t < 8; t++) begin
         if (in_ready) begin
            accepted = 1'b1;
            @(negedge clk);
            break;
         end
         @(negedge clk);
      end
   endtask

   // Assert reset part-way through a high clock phase and check that the
   // outputs fall back without any clock edge, then release it.
   task automatic resetPulse();
      @(posedge clk);
      #3;
      rst      = 1'b1;
      in_valid = 1'b0;
      #1;
      checkOutput("rst.in_ready", {31'h0, in_ready}, 32'h1);
      checkOutput("rst.mem_enable", {31'h0, mem_enable}, 32'h0);
      checkOutput("rst.mem_wr", {31'h0, mem_wr}, 32'h0);
      checkOutput("rst.mem_addr", mem_addr, BASE);
      checkOutput("rst.mem_data", mem_data, 32'h0);
      checkOutput("rst.cpu_rst", {31'h0, cpu_rst}, 32'h1);
      checkOutput("rst.done", {31'h0, done}, 32'h0);
      checkOutput("rst.error", {31'h0, error}, 32'h0);
      checkOutput("rst.words_written", {16'h0, words_written}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("rst.release_ready", {31'h0, in_ready}, 32'h1);
   endtask

   // Stream one complete image and compare flags, write log and counter
   // against the expectations supplied by the caller.
   task automatic applyStimulus(input logic [15:0] len, input logic [31:0] w [4],
                                input logic [7:0] csum, input int gapMax,
                                input bit expDone, input bit expErr,
                                input int expWrites, input string tag);
      int          base;
      bit          acc;
      logic [31:0] tmp;
      base = writes.size();
      sendByte(len[7:0], gapMax, acc);
      checkOutput({tag, ".acc_len_lo"}, {31'h0, acc}, 32'h1);
      sendByte(len[15:8], gapMax, acc);
      checkOutput({tag, ".acc_len_hi"}, {31'h0, acc}, 32'h1);
      if (int'(len) > MAXW) begin
         checkOutput({tag, ".len_error"}, {31'h0, error}, 32'h1);
         checkOutput({tag, ".len_cpu_rst"}, {31'h0, cpu_rst}, 32'h1);
         in_valid = 1'b1;
         in_data  = 8'hA5;
         repeat (3) begin
            checkOutput({tag, ".err_ready"}, {31'h0, in_ready}, 32'h0);
            @(negedge clk);
         end
      end else begin
         for (int i = 0; i < int'(len); i++) begin
            for (int k = 0; k < 4; k++) begin
               tmp = w[i] >> (8 * k);
               sendByte(tmp[7:0], gapMax, acc);
               checkOutput({tag, ".acc_data"}, {31'h0, acc}, 32'h1);
            end
         end
         sendByte(csum, gapMax, acc);
         checkOutput({tag, ".acc_csum"}, {31'h0, acc}, 32'h1);
         checkOutput({tag, ".done"}, {31'h0, done}, {31'h0, expDone});
         checkOutput({tag, ".error"}, {31'h0, error}, {31'h0, expErr});
         checkOutput({tag, ".cpu_rst"}, {31'h0, cpu_rst}, {31'h0, !expDone});
         checkOutput({tag, ".end_ready"}, {31'h0, in_ready}, 32'h0);
      end
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput({tag, ".words_written"}, {16'h0, words_written}, 32'(expWrites));
      checkOutput({tag, ".strobe_cycles"}, 32'(writes.size() - base), 32'(expWrites));
      for (int i = 0; i < expWrites && (base + i) < writes.size(); i++) begin
         checkOutput({tag, ".wr_addr"}, writes[base + i].addr, BASE + 32'(4 * i));
         checkOutput({tag, ".wr_data"}, writes[base + i].data, w[i]);
         checkOutput({tag, ".wr_strobe"}, {31'h0, writes[base + i].en & writes[base + i].wr}, 32'h1);
         checkOutput({tag, ".wr_ready_low"}, {31'h0, writes[base + i].rdy}, 32'h0);
      end
   endtask

   vec_t        vecs[6];
   logic [31:0] rw [4];
   logic [15:0] rlen;
   logic [7:0]  rcsum;
   int          r;
   int          base;
   bit          acc;
   bit          rDone;
   logic [31:0] tmp;

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;

      // Byte sum of 02 00 EF BE AD DE 78 56 34 12 is 0x4E, so 0x84 and 0x4F
      // are both bad checksums for the two-word image.
      vecs[0] = '{16'd2, '{32'hDEADBEEF, 32'h12345678, 32'h0, 32'h0}, 8'h4E, 1'b1, 1'b0, 2, "two_word"};
      vecs[1] = '{16'd2, '{32'hDEADBEEF, 32'h12345678, 32'h0, 32'h0}, 8'h84, 1'b0, 1'b1, 2, "bad_csum"};
      vecs[2] = '{16'd0, '{32'h0, 32'h0, 32'h0, 32'h0}, 8'h00, 1'b1, 1'b0, 0, "zero_len"};
      vecs[3] = '{16'd5, '{32'h0, 32'h0, 32'h0, 32'h0}, 8'h00, 1'b0, 1'b1, 0, "oversize"};
      vecs[4] = '{16'd4, '{32'h1, 32'h2, 32'h3, 32'h4}, 8'h0E, 1'b1, 1'b0, 4, "max_len"};
      vecs[5] = '{16'h0100, '{32'h0, 32'h0, 32'h0, 32'h0}, 8'h00, 1'b0, 1'b1, 0, "len_hi_big"};

      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      for (int v = 0; v < 6; v++) begin
         resetPulse();
         applyStimulus(vecs[v].len, vecs[v].w, vecs[v].csum, 0, vecs[v].expDone,
                       vecs[v].expErr, vecs[v].expWrites, vecs[v].tag);
      end

      // Gappy source, reset after the sixth data byte: word 0 must already
      // have been written once, and a fresh image must then load cleanly.
      resetPulse();
      base = writes.size();
      rw[0] = $urandom;
      rw[1] = $urandom;
      rw[2] = 32'h0;
      rw[3] = 32'h0;
      sendByte(8'd2, 3, acc);
      sendByte(8'd0, 3, acc);
      for (int n = 0; n < 6; n++) begin
         tmp = rw[n / 4] >> (8 * (n % 4));
         sendByte(tmp[7:0], 3, acc);
         checkOutput("midrst.acc_data", {31'h0, acc}, 32'h1);
      end
      #2;
      rst      = 1'b1;
      in_valid = 1'b0;
      #1;
      checkOutput("midrst.words_written", {16'h0, words_written}, 32'h0);
      checkOutput("midrst.in_ready", {31'h0, in_ready}, 32'h1);
      checkOutput("midrst.cpu_rst", {31'h0, cpu_rst}, 32'h1);
      checkOutput("midrst.mem_wr", {31'h0, mem_wr}, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      checkOutput("midrst.word0_once", 32'(writes.size() - base), 32'h1);
      if (writes.size() > base) begin
         checkOutput("midrst.word0_data", writes[base].data, rw[0]);
         checkOutput("midrst.word0_addr", writes[base].addr, BASE);
      end
      rw[0] = $urandom;
      rw[1] = $urandom;
      rw[2] = $urandom;
      applyStimulus(16'd3, rw, refChecksum(16'd3, rw), 2, 1'b1, 1'b0, 3, "midrst.reload");

      // Random images against the byte-sum model.
      for (int it = 0; it < 25; it++) begin
         r = int'($urandom_range(9, 0));
         if (r <= 4) begin
            rlen = 16'(r);
         end else if (r <= 6) begin
            rlen = 16'(MAXW + 1);
         end else begin
            rlen = 16'($urandom);
         end
         for (int i = 0; i < 4; i++) begin
            rw[i] = $urandom;
         end
         rcsum = refChecksum(rlen, rw);
         if ($urandom_range(3, 0) == 0) begin
            rcsum = rcsum ^ 8'($urandom_range(255, 1));
         end
         rDone = (int'(rlen) <= MAXW) && (rcsum == refChecksum(rlen, rw));
         resetPulse();
         applyStimulus(rlen, rw, rcsum, 3, rDone, !rDone,
                       (int'(rlen) <= MAXW) ? int'(rlen) : 0, "random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
